mac_ctrl: RTL and testbench
===========================

# mac_ctrl

Sequencer for the 8x8 int8 matrix-multiply engine: on START it decodes the M/N/T shape word and walks the input SRAM (T rows) and the transposed-weight SRAM (M rows). For every (t,m) pair it launches one dot product on the MAC datapath. It packs four 16-bit results per 64-bit word and writes all 16 output-SRAM entries, zero-filling unused positions. It sits between the three single-port synchronous SRAMs (1-cycle read latency) and the MAC datapath, and owns every memory enable and address.

## Interface
- `OUT_ENTRIES`, default 16: output SRAM depth; always fully written.
- `DIM_MAX`, default 8: maximum legal M, N, T.
- `CLK` in 1: clock.
- `RSTN` in 1: reset, asynchronous, active-low.
- `START` in 1: run request, level; a run arms only after START has been seen low since the previous run.
- `MNT` in 12: shape word, M=[11:8], N=[7:4], T=[3:0]; sampled on accept.
- `BUSY` out 1: high from the accept+1 cycle through the last write.
- `DONE` out 1: one-cycle pulse at run end.
- `ERR` out 1: valid with DONE; 1 = shape rejected.
- `EN_I` out 1 / `ADDR_I` out 3: input SRAM read enable and row address.
- `EN_W` out 1 / `ADDR_W` out 3: weight SRAM read enable and row address.
- `EN_O` out 1 / `RW_O` out 1 / `ADDR_O` out 4 / `WDATA_O` out 64: output SRAM port; RW_O=1 means write.
- `DP_LD_I` out 1: datapath latches RDATA_I as the input row.
- `DP_LD_W` out 1: datapath latches RDATA_W as the weight row.
- `DP_GO` out 1: starts a dot product; same cycle as DP_LD_W.
- `DP_NMASK` out 8: bit k enables element k at bits [63-8k -: 8]; value (1<<N)-1; stable while BUSY.
- `DP_DONE` in 1 / `DP_RES` in 16: result strobe and value, taken as-is with no saturation by this block.

## Operation
- Reset values: all outputs 0 and state IDLE. Reset mid-run aborts immediately; no further memory access occurs.
- IDLE: accept when START=1, armed, and MNT is legal. An illegal MNT (any field 0 or >8) gives DONE=1 and ERR=1 the next cycle, with no memory access.
- Per row t<T, the states run in this order:
  - RD_I: EN_I=1, ADDR_I=t.
  - LD_I: DP_LD_I=1.
  - Per column m<M:
    - RD_W: EN_W=1, ADDR_W=m.
    - GO: DP_LD_W=1, DP_GO=1.
    - WAIT: hold until DP_DONE=1, then store DP_RES in slot m%4.
  - WR: issued after slot 3 or after the last m.
- Word packing: slot 0 at [63:48] through slot 3 at [15:0]. Unfilled slots are 0. ADDR_O=2t for columns 0-3 and 2t+1 for columns 4-7.
- If M≤4, word 2t+1 is written as all zeros without any compute.
- Rows t≥T: two WR cycles of zeros to 2t and 2t+1, with no SRAM reads.
- After address 15 is written: state DONE (DONE=1, ERR=0), then IDLE. BUSY is low in the DONE cycle.
- DP_DONE outside WAIT is ignored. START changes while BUSY are ignored.
- After DONE, START must be seen low at least one cycle before the next accept, so START held high gives exactly one run.

## Timing
- Accept at cycle 0; the first state (RD_I, or WR for T=0 rejected earlier) is at cycle 1.
- Datapath latency L≥1: DP_DONE is sampled no earlier than the cycle after GO. WAIT lasts L cycles.
- Cycles for a computed row: 2 + M·(2+L) + 2. Cycles for a zero row: 2.
- Run length is the sum over rows plus 1 DONE cycle. Example: MNT=12'h888, L=1 gives 8·28 + 1 = 225, so DONE is at cycle 225.
- Each SRAM enable is a single-cycle pulse; RDATA is consumed exactly one cycle later.
- At most one SRAM is enabled per cycle.

## Structure
- Package `mac_pkg` holds:
  - MNT field positions, DIM_MAX, OUT_ENTRIES.
  - The state enum: IDLE, RD_I, LD_I, RD_W, GO, WAIT, WR, ZWR, FIN.
  - Slot width (16) and slot count (4).
- Sub-module `mac_out_packer`: a 4x16 slot register with clear, slot write, and a 64-bit concatenated output.
- Counters in the top level: t (0-7), m (0-7), and the out address (0-15).

## Test plan
- MNT=12'h888, datapath model L=1:
  - DONE at cycle 225 after accept, ERR=0.
  - 16 writes at addresses 0..15 in order.
  - Each word matches the golden int8 dot products.
- MNT=12'h325 (M=3, N=2, T=5):
  - DP_NMASK=8'h03 and ADDR_W only takes values 0-2.
  - Even addresses hold the 3 results with [15:0]=0.
  - Odd addresses and addresses 10-15 hold 64'h0.
- MNT=12'h058 and MNT=12'h889:
  - DONE and ERR pulse at cycle 1.
  - No EN_I, EN_W or EN_O activity.
- DP latency L=5 plus spurious DP_DONE pulses during RD_W:
  - Results unchanged.
  - Run length 8·(4+8·7) + 1 = 481.
- RSTN low at cycle 60 of an 888 run:
  - All outputs 0 immediately and no writes afterwards.
  - A new START after reset completes normally.
- START held high for 600 cycles: exactly one DONE. Dropping START for 1 cycle then raising it starts a second run.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared constants, state encoding and helpers for the matrix-multiply
// sequencer and its output packer.
package mac_pkg;

    localparam int DIM_MAX     = 8;
    localparam int OUT_ENTRIES = 16;
    localparam int SLOT_W      = 16;
    localparam int SLOTS       = 4;

    localparam int M_MSB = 11;
    localparam int M_LSB = 8;
    localparam int N_MSB = 7;
    localparam int N_LSB = 4;
    localparam int T_MSB = 3;
    localparam int T_LSB = 0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_I,
        ST_LD_I,
        ST_RD_W,
        ST_GO,
        ST_WAIT,
        ST_WR,
        ST_ZWR,
        ST_FIN
    } state_e;

    function automatic logic [7:0] n_to_mask(input logic [3:0] n);
        logic [8:0] m;
        m = (9'd1 << n) - 9'd1;
        return m[7:0];
    endfunction

endpackage

// File: rtl/mac_out_packer.sv
// Four 16-bit result slots concatenated into one 64-bit output word,
// slot 0 in the most significant position.
module mac_out_packer
    import mac_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clr_i,
    input  logic                    wr_i,
    input  logic [1:0]              slot_i,
    input  logic [SLOT_W-1:0]       data_i,
    output logic [SLOTS*SLOT_W-1:0] word_o
);

    logic [SLOTS-1:0][SLOT_W-1:0] slot_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_q <= '0;
        end else if (clr_i) begin
            slot_q <= '0;
        end else if (wr_i) begin
            slot_q[slot_i] <= data_i;
        end
    end

    assign word_o = {slot_q[0], slot_q[1], slot_q[2], slot_q[3]};

endmodule

// File: rtl/mac_ctrl.sv
// Sequencer for the 8x8 int8 matrix-multiply engine: walks the input and
// weight SRAMs, drives the MAC datapath and fills all output SRAM entries.
module mac_ctrl #(
    parameter int OUT_ENTRIES = 16,
    parameter int DIM_MAX     = 8
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        START,
    input  logic [11:0] MNT,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic        EN_I,
    output logic [2:0]  ADDR_I,
    output logic        EN_W,
    output logic [2:0]  ADDR_W,
    output logic        EN_O,
    output logic        RW_O,
    output logic [3:0]  ADDR_O,
    output logic [63:0] WDATA_O,
    output logic        DP_LD_I,
    output logic        DP_LD_W,
    output logic        DP_GO,
    output logic [7:0]  DP_NMASK,
    input  logic        DP_DONE,
    input  logic [15:0] DP_RES
);

    import mac_pkg::*;

    state_e      state_q, state_d;
    logic [2:0]  t_q, t_d, m_q, m_d;
    logic [3:0]  addr_q, addr_d;
    logic [3:0]  mlim_q, mlim_d, tlim_q, tlim_d;
    logic [7:0]  nmask_q, nmask_d;
    logic        armed_q, armed_d, err_q, err_d;
    logic        pk_clr, pk_wr;
    logic [63:0] pk_word;
    logic [3:0]  f_m, f_n, f_t, t_nxt;
    logic        legal, last_m, last_addr;

    assign f_m = MNT[M_MSB:M_LSB];
    assign f_n = MNT[N_MSB:N_LSB];
    assign f_t = MNT[T_MSB:T_LSB];

    assign legal = (f_m != 4'd0) && (f_m <= 4'(DIM_MAX))
                && (f_n != 4'd0) && (f_n <= 4'(DIM_MAX))
                && (f_t != 4'd0) && (f_t <= 4'(DIM_MAX));

    assign last_m    = ({1'b0, m_q} == mlim_q - 4'd1);
    assign last_addr = (addr_q == 4'(OUT_ENTRIES - 1));
    assign t_nxt     = {1'b0, t_q} + 4'd1;

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        m_d     = m_q;
        addr_d  = addr_q;
        mlim_d  = mlim_q;
        tlim_d  = tlim_q;
        nmask_d = nmask_q;
        armed_d = armed_q;
        err_d   = err_q;
        pk_clr  = 1'b0;
        pk_wr   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (START && armed_q) begin
                    armed_d = 1'b0;
                    if (legal) begin
                        mlim_d  = f_m;
                        tlim_d  = f_t;
                        nmask_d = n_to_mask(f_n);
                        t_d     = '0;
                        m_d     = '0;
                        addr_d  = '0;
                        err_d   = 1'b0;
                        pk_clr  = 1'b1;
                        state_d = ST_RD_I;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_FIN;
                    end
                end else if (!START) begin
                    armed_d = 1'b1;
                end
            end
            ST_RD_I: state_d = ST_LD_I;
            ST_LD_I: state_d = ST_RD_W;
            ST_RD_W: state_d = ST_GO;
            ST_GO:   state_d = ST_WAIT;
            ST_WAIT: begin
                if (DP_DONE) begin
                    pk_wr = 1'b1;
                    if (m_q[1:0] == 2'd3 || last_m) begin
                        state_d = ST_WR;
                    end else begin
                        m_d     = m_q + 3'd1;
                        state_d = ST_RD_W;
                    end
                end
            end
            ST_WR, ST_ZWR: begin
                addr_d = addr_q + 4'd1;
                pk_clr = 1'b1;
                if (last_addr) begin
                    state_d = ST_FIN;
                end else if (!addr_q[0]) begin
                    // Upper half of a row: more columns, or a zero word
                    if (state_q == ST_WR && !last_m) begin
                        m_d     = m_q + 3'd1;
                        state_d = ST_RD_W;
                    end else begin
                        state_d = ST_ZWR;
                    end
                end else begin
                    t_d     = t_nxt[2:0];
                    m_d     = '0;
                    state_d = (t_nxt < tlim_q) ? ST_RD_I : ST_ZWR;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                if (!START) armed_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            m_q     <= '0;
            addr_q  <= '0;
            mlim_q  <= '0;
            tlim_q  <= '0;
            nmask_q <= '0;
            armed_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            m_q     <= m_d;
            addr_q  <= addr_d;
            mlim_q  <= mlim_d;
            tlim_q  <= tlim_d;
            nmask_q <= nmask_d;
            armed_q <= armed_d;
            err_q   <= err_d;
        end
    end

    mac_out_packer u_packer (
        .clk_i  (CLK),
        .rst_ni (RSTN),
        .clr_i  (pk_clr),
        .wr_i   (pk_wr),
        .slot_i (m_q[1:0]),
        .data_i (DP_RES),
        .word_o (pk_word)
    );

    assign BUSY     = (state_q != ST_IDLE) && (state_q != ST_FIN);
    assign DONE     = (state_q == ST_FIN);
    assign ERR      = DONE && err_q;
    assign EN_I     = (state_q == ST_RD_I);
    assign ADDR_I   = EN_I ? t_q : '0;
    assign EN_W     = (state_q == ST_RD_W);
    assign ADDR_W   = EN_W ? m_q : '0;
    assign EN_O     = (state_q == ST_WR) || (state_q == ST_ZWR);
    assign RW_O     = EN_O;
    assign ADDR_O   = EN_O ? addr_q : '0;
    assign WDATA_O  = (state_q == ST_WR) ? pk_word : '0;
    assign DP_LD_I  = (state_q == ST_LD_I);
    assign DP_LD_W  = (state_q == ST_GO);
    assign DP_GO    = (state_q == ST_GO);
    assign DP_NMASK = nmask_q;

endmodule

// File: tb/tb_mac_ctrl.sv
// Bench for mac_ctrl: SRAM and datapath models plus a write scoreboard
// fed with golden int8 dot products.
module tb_mac_ctrl;

    logic        CLK   = 1'b0;
    logic        RSTN  = 1'b0;
    logic        START = 1'b0;
    logic [11:0] MNT   = 12'h0;
    logic        BUSY, DONE, ERR, EN_I, EN_W, EN_O, RW_O;
    logic        DP_LD_I, DP_LD_W, DP_GO, DP_DONE;
    logic [2:0]  ADDR_I, ADDR_W;
    logic [3:0]  ADDR_O;
    logic [63:0] WDATA_O;
    logic [7:0]  DP_NMASK;
    logic [15:0] DP_RES;
    logic [91:0] all_outs;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    mac_ctrl dut (
        .CLK(CLK), .RSTN(RSTN), .START(START), .MNT(MNT),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
        .EN_I(EN_I), .ADDR_I(ADDR_I), .EN_W(EN_W), .ADDR_W(ADDR_W),
        .EN_O(EN_O), .RW_O(RW_O), .ADDR_O(ADDR_O), .WDATA_O(WDATA_O),
        .DP_LD_I(DP_LD_I), .DP_LD_W(DP_LD_W), .DP_GO(DP_GO),
        .DP_NMASK(DP_NMASK), .DP_DONE(DP_DONE), .DP_RES(DP_RES)
    );

    assign all_outs = {BUSY, DONE, ERR, EN_I, ADDR_I, EN_W, ADDR_W, EN_O,
                       RW_O, ADDR_O, WDATA_O, DP_LD_I, DP_LD_W, DP_GO,
                       DP_NMASK};

    // SRAM models, one-cycle read latency
    logic [63:0] imem [8];
    logic [63:0] wmem [8];
    logic [63:0] rdata_i = '0;
    logic [63:0] rdata_w = '0;

    always @(posedge CLK) begin
        if (EN_I) rdata_i <= imem[ADDR_I];
        if (EN_W) rdata_w <= wmem[ADDR_W];
    end

    // Datapath model with programmable latency and spurious strobes
    int          dp_lat  = 1;
    bit          spur_en = 1'b0;
    int          dp_cnt  = 0;
    logic [63:0] dp_in   = '0;
    logic [15:0] dp_val  = '0;

    function automatic logic [15:0] dp_dot(input logic [63:0] x,
                                           input logic [63:0] w,
                                           input logic [7:0]  msk);
        int s;
        s = 0;
        for (int k = 0; k < 8; k++)
            if (msk[k])
                s += $signed(x[63-8*k -: 8]) * $signed(w[63-8*k -: 8]);
        return 16'(s);
    endfunction

    always @(posedge CLK) begin
        if (DP_LD_I) dp_in <= rdata_i;
        if (DP_GO) begin
            dp_cnt <= dp_lat;
            dp_val <= dp_dot(dp_in, rdata_w, DP_NMASK);
        end else if (dp_cnt > 0) begin
            dp_cnt <= dp_cnt - 1;
        end
    end

    assign DP_DONE = (dp_cnt == 1) || (spur_en && EN_W);
    assign DP_RES  = (dp_cnt == 1) ? dp_val : 16'hDEAD;

    // Golden model and scoreboard
    logic [3:0]  exp_a [$];
    logic [63:0] exp_d [$];

    function automatic logic [15:0] gold_dot(input int t, input int m,
                                             input int n);
        logic signed [7:0] a, b;
        logic [15:0] acc;
        acc = '0;
        for (int k = 0; k < n; k++) begin
            a = imem[t][63-8*k -: 8];
            b = wmem[m][63-8*k -: 8];
            acc = acc + 16'(int'(a) * int'(b));
        end
        return acc;
    endfunction

    task automatic push_expected(input int mm, input int nn, input int tt);
        logic [63:0] w;
        for (int a = 0; a < 16; a++) begin
            w = '0;
            if (a / 2 < tt)
                for (int s = 0; s < 4; s++)
                    if ((a % 2) * 4 + s < mm)
                        w[63-16*s -: 16] = gold_dot(a / 2, (a % 2) * 4 + s, nn);
            exp_a.push_back(4'(a));
            exp_d.push_back(w);
        end
    endtask

    int n_en_i = 0, n_en_w = 0, n_en_o = 0, n_multi = 0, n_done = 0;
    int maxw = 0, done_cyc = 0;
    logic done_err = 1'b0, done_busy = 1'b0;

    always @(negedge CLK) begin
        logic [3:0]  ea;
        logic [63:0] ed;
        if (EN_I) n_en_i++;
        if (EN_W) begin
            n_en_w++;
            if (int'(ADDR_W) > maxw) maxw = int'(ADDR_W);
        end
        if (EN_O) n_en_o++;
        if (int'(EN_I) + int'(EN_W) + int'(EN_O) > 1) n_multi++;
        if (DONE) begin
            n_done++;
            done_cyc  = cyc;
            done_err  = ERR;
            done_busy = BUSY;
        end
        if (EN_O && RW_O) begin
            checks++;
            if (exp_a.size() == 0) begin
                errors++;
                $display("FAIL sb_extra: write addr=%0d data=%h, expected none",
                         ADDR_O, WDATA_O);
            end else begin
                ea = exp_a.pop_front();
                ed = exp_d.pop_front();
                if (ADDR_O !== ea || WDATA_O !== ed) begin
                    errors++;
                    $display("FAIL sb_word: got addr=%0d data=%h, expected addr=%0d data=%h",
                             ADDR_O, WDATA_O, ea, ed);
                end
            end
        end
    end

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic launch(input logic [11:0] mnt, output int t0);
        START = 1'b0;
        tick();
        tick();
        MNT   = mnt;
        START = 1'b1;
        t0    = cyc;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int d0;
        d0 = n_done;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (n_done != d0) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        RSTN  = 1'b0;
        START = 1'b0;
        tick();
        checks++;
        if (all_outs !== '0) begin
            errors++;
            $display("FAIL reset_outs: got %h, expected 0", all_outs);
        end
        tick();
        RSTN = 1'b1;
        repeat (4) tick();
        checks++;
        if (n_en_i + n_en_w + n_en_o + n_done != 0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: activity=%0d busy=%b, expected 0 0",
                     n_en_i + n_en_w + n_en_o + n_done, BUSY);
        end
    endtask

    task automatic test_full_888();
        int t0;
        bit ok;
        dp_lat = 1;
        push_expected(8, 8, 8);
        launch(12'h888, t0);
        checks++;
        if (BUSY !== 1'b0) begin
            errors++;
            $display("FAIL f888_busy0: got %b, expected 0", BUSY);
        end
        tick();
        checks++;
        if (BUSY !== 1'b1 || EN_I !== 1'b1 || DP_NMASK !== 8'hFF) begin
            errors++;
            $display("FAIL f888_first: busy=%b en_i=%b mask=%h, expected 1 1 ff",
                     BUSY, EN_I, DP_NMASK);
        end
        wait_done(400, ok);
        checks++;
        if (!ok || done_cyc - t0 != 225) begin
            errors++;
            $display("FAIL f888_len: done=%0b cycles=%0d, expected 1 225",
                     ok, done_cyc - t0);
        end
        checks++;
        if (done_err !== 1'b0 || done_busy !== 1'b0) begin
            errors++;
            $display("FAIL f888_flags: err=%b busy=%b, expected 0 0",
                     done_err, done_busy);
        end
        checks++;
        if (exp_a.size() != 0 || n_multi != 0) begin
            errors++;
            $display("FAIL f888_sb: left=%0d multi_en=%0d, expected 0 0",
                     exp_a.size(), n_multi);
        end
    endtask

    task automatic test_partial_325();
        int t0, ei, ew;
        bit ok;
        maxw = 0;
        ei   = n_en_i;
        ew   = n_en_w;
        push_expected(3, 2, 5);
        launch(12'h325, t0);
        tick();
        checks++;
        if (DP_NMASK !== 8'h03) begin
            errors++;
            $display("FAIL p325_mask: got %h, expected 03", DP_NMASK);
        end
        wait_done(200, ok);
        checks++;
        if (!ok || done_cyc - t0 != 72) begin
            errors++;
            $display("FAIL p325_len: done=%0b cycles=%0d, expected 1 72",
                     ok, done_cyc - t0);
        end
        checks++;
        if (maxw != 2 || n_en_w - ew != 15 || n_en_i - ei != 5) begin
            errors++;
            $display("FAIL p325_reads: maxw=%0d en_w=%0d en_i=%0d, expected 2 15 5",
                     maxw, n_en_w - ew, n_en_i - ei);
        end
        checks++;
        if (exp_a.size() != 0) begin
            errors++;
            $display("FAIL p325_sb: left=%0d, expected 0", exp_a.size());
        end
    endtask

    task automatic test_illegal();
        logic [11:0] bad [2];
        int t0, act;
        bit ok;
        bad[0] = 12'h058;
        bad[1] = 12'h889;
        for (int i = 0; i < 2; i++) begin
            act = n_en_i + n_en_w + n_en_o;
            launch(bad[i], t0);
            wait_done(10, ok);
            checks++;
            if (!ok || done_cyc - t0 != 1 || done_err !== 1'b1) begin
                errors++;
                $display("FAIL illegal_%h: done=%0b cycles=%0d err=%b, expected 1 1 1",
                         bad[i], ok, done_cyc - t0, done_err);
            end
            tick();
            checks++;
            if (n_en_i + n_en_w + n_en_o != act) begin
                errors++;
                $display("FAIL illegal_mem_%h: accesses=%0d, expected 0",
                         bad[i], n_en_i + n_en_w + n_en_o - act);
            end
        end
    endtask

    task automatic test_latency_spurious();
        int t0;
        bit ok;
        dp_lat  = 5;
        spur_en = 1'b1;
        push_expected(8, 8, 8);
        launch(12'h888, t0);
        wait_done(700, ok);
        checks++;
        if (!ok || done_cyc - t0 != 481) begin
            errors++;
            $display("FAIL lat5_len: done=%0b cycles=%0d, expected 1 481",
                     ok, done_cyc - t0);
        end
        checks++;
        if (exp_a.size() != 0) begin
            errors++;
            $display("FAIL lat5_sb: left=%0d, expected 0", exp_a.size());
        end
        dp_lat  = 1;
        spur_en = 1'b0;
    endtask

    task automatic test_midrun_reset();
        int t0, act;
        bit ok;
        push_expected(8, 8, 8);
        launch(12'h888, t0);
        for (int i = 0; i < 100 && cyc < t0 + 60; i++) tick();
        RSTN = 1'b0;
        #1;
        checks++;
        if (all_outs !== '0) begin
            errors++;
            $display("FAIL rst_outs: got %h, expected 0", all_outs);
        end
        act = n_en_i + n_en_w + n_en_o;
        repeat (3) tick();
        RSTN = 1'b1;
        repeat (20) tick();
        checks++;
        if (n_en_i + n_en_w + n_en_o != act || exp_a.size() != 12) begin
            errors++;
            $display("FAIL rst_quiet: new_accesses=%0d pending=%0d, expected 0 12",
                     n_en_i + n_en_w + n_en_o - act, exp_a.size());
        end
        exp_a.delete();
        exp_d.delete();
        push_expected(8, 8, 8);
        launch(12'h888, t0);
        wait_done(400, ok);
        checks++;
        if (!ok || done_cyc - t0 != 225 || exp_a.size() != 0) begin
            errors++;
            $display("FAIL rst_rerun: done=%0b cycles=%0d left=%0d, expected 1 225 0",
                     ok, done_cyc - t0, exp_a.size());
        end
    endtask

    task automatic test_start_level();
        int t0, d0;
        bit ok;
        push_expected(8, 8, 8);
        launch(12'h888, t0);
        d0 = n_done;
        repeat (600) tick();
        checks++;
        if (n_done - d0 != 1 || exp_a.size() != 0) begin
            errors++;
            $display("FAIL lvl_once: dones=%0d left=%0d, expected 1 0",
                     n_done - d0, exp_a.size());
        end
        push_expected(8, 8, 8);
        START = 1'b0;
        tick();
        START = 1'b1;
        t0    = cyc;
        wait_done(300, ok);
        checks++;
        if (!ok || done_cyc - t0 != 225 || exp_a.size() != 0) begin
            errors++;
            $display("FAIL lvl_second: done=%0b cycles=%0d left=%0d, expected 1 225 0",
                     ok, done_cyc - t0, exp_a.size());
        end
        START = 1'b0;
    endtask

    initial begin
        for (int r = 0; r < 8; r++) begin
            imem[r] = {$urandom, $urandom};
            wmem[r] = {$urandom, $urandom};
        end
        imem[0] = 64'h8080_8080_8080_8080;
        wmem[0] = 64'h8080_8080_8080_8080;
        wmem[1] = 64'h7F7F_7F7F_8080_8080;
        test_reset();
        test_full_888();
        test_partial_325();
        test_illegal();
        test_latency_spurious();
        test_midrun_reset();
        test_start_level();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
